ctrlpid_mc: RTL and testbench
=============================

Name: ctrlpid_mc

Overview:
Time-multiplexed, N-channel discrete fixed-point PID controller using shift-only (2^n) gains. It is the parametrised successor of the single-loop shift-gain PID, generalised to 2^aw channels. It adds an external sample tick, per-term enables, per-channel disable/clear, overrun detection and saturating clamp. It sits between the quadrature/error source and the PWM generators in the SoC motor-control path, with one shared arithmetic datapath and per-channel state held in register arrays.

Parameters:
aw, 2, channel address width; channel count an = 2^aw
ew, 24, error input width (ew < pw)
pw, 32, internal accumulator width
ow, 12, output width (signed)
cw, 6, gain shift width (signed)
precision, 1, fixed-point guard bits added to every gain
fp, 9, log2 of the control loop frequency in Hz
antiwindup, 8'hFF << (precision+ow-9), accumulator clamp magnitude (default 4080)

Ports:
clk_pid  in  1  clock
reset  in  1  asynchronous, active-high reset
tick  in  1  sample strobe; starts one sweep over all channels
a  out  aw  channel currently being processed; error/KP/KI/KD/mode/ch_en are read combinationally at this address
error  in  ew  signed error for channel a
KP, KI, KD  in  cw each  signed shift gains for channel a (-32..31)
mode  in  3  per-term enable {D,I,P} for channel a
ch_en  in  1  channel enable for channel a
m_k_out  out  ow  signed output of channel m_addr
m_addr  out  aw  channel index of m_k_out
m_valid  out  1  one-cycle pulse: m_k_out/m_addr are valid
busy  out  1  sweep in progress
overrun  out  1  sticky: tick arrived while busy

Behaviour:
- Reset: state IDLE, a=0, m_k_out=0, m_addr=0, m_valid=0, busy=0, overrun=0. All per-channel u_k, e_k_0, e_k_1 and e_k_2 are cleared to 0.
- Effective shifts: Kp=KP+precision; Ki1=KI+precision-1-fp; Kd=KD+precision+fp; Kd1=Kd+1. All are cw-bit signed. A non-negative shift is an arithmetic left shift (<<<); a negative shift is an arithmetic right shift by its magnitude.
- FSM: IDLE -> LOAD -> PTERM -> DTERM -> ITERM -> D2TERM -> CLAMP -> OUT -> SHIFT.
  - From SHIFT: go to LOAD with a+1, or go to IDLE and set a=0 if a==an-1.
  - 8 cycles per channel; one sweep is 8*an cycles.
- IDLE: when tick=1, go to LOAD next cycle and set busy=1. busy drops on the cycle IDLE is re-entered.
- LOAD: capture error sign-extended to pw into e_k_0[a]; latch gains, mode and ch_en into working registers.
- PTERM (if mode[0]): u += (e0<<<Kp) - (e1<<<Kp).
- DTERM (if mode[2]): u += sh(e0,Kd) + sh(e2,Kd).
- ITERM (if mode[1]): u += sh(e0,Ki1) + sh(e1,Ki1).
- D2TERM (if mode[2]): u -= sh(e1,Kd1).
- Term arithmetic is performed at pw+2 bits. A disabled term leaves u unchanged.
- CLAMP: saturate the pw+2 result to [-antiwindup, +antiwindup] and store it in u_k[a]. Saturation happens in one cycle.
- OUT: m_k_out <= u[precision+ow-1:precision]; m_addr <= a; m_valid pulses the following cycle.
- SHIFT: e_k_2 <= e_k_1; e_k_1 <= e_k_0.
- ch_en=0 at LOAD: the channel skips the arithmetic. u_k, e_k_0, e_k_1 and e_k_2 are all zeroed, and OUT still emits m_k_out=0 with m_valid. Channel timing is unchanged.
- tick while busy: ignored and sets overrun=1. overrun clears only on reset.
- Simultaneous tick and final SHIFT: counts as overrun; the sweep is not restarted.
- reset mid-sweep: the sweep is abandoned immediately and all state is cleared.
- Gain shifts at or beyond pw in either direction yield 0 (right shift of a positive value) or -1 (right shift of a negative value), or bits are discarded (left shift); no X propagation.

Decomposition:
- Shared package: state encoding constants (IDLE..SHIFT), mode bit indices (MODE_P=0, MODE_I=1, MODE_D=2), and the default antiwindup expression.
- One sub-module, ctrlpid_shift: a combinational signed bidirectional arithmetic shifter (pw-bit data, cw-bit signed amount). It is instantiated once and muxed per state.

Test Plan:
- Default params, ch0 P-only (mode=001, KP=0), error=100: sweep1 gives m_addr=0, m_k_out=100. Sweep2 with the same error keeps 100 and u_k stays 200.
- I-only (mode=010, KI=9 so Ki1=0), constant error=10: outputs over successive sweeps are 5, 15, 25.
- Clamp, P-only KP=0, error=+5000: m_k_out=2040. With error=-5000 after a clear: m_k_out=-2040. u_k must never exceed ±4080.
- Multi-channel, aw=2: each channel gets a different error (10, 20, -30, 0), P-only. Require four m_valid pulses 8 cycles apart, m_addr 0..3, outputs 10, 20, -30, 0, and busy high for exactly 32 cycles.
- Overrun and disable:
  - A second tick 5 cycles after the first sets overrun=1 and the sweep completes normally.
  - ch_en=0 on ch1 zeroes ch1 history and gives m_k_out=0 for ch1.
- Reset mid-sweep, asserted at cycle 12: outputs go to 0 and busy to 0 immediately. A following tick reproduces the first-sweep values from the P-only test (m_k_out=100).

Source files
------------

// File: rtl/ctrlpid_mc_pkg.sv
// rtl/ctrlpid_mc_pkg.sv - shared state encoding, mode bits and default clamp for the multichannel PID
package ctrlpid_mc_pkg;

  typedef enum logic [3:0] {
    IDLE,
    LOAD,
    PTERM,
    DTERM,
    ITERM,
    D2TERM,
    CLAMP,
    OUT,
    SHIFT
  } state_e;

  localparam int MODE_P = 0;
  localparam int MODE_I = 1;
  localparam int MODE_D = 2;

  // Evaluated at int width so the 8-bit seed is not truncated by the shift.
  function automatic int antiwindup_default(input int precision, input int ow);
    return 255 << (precision + ow - 9);
  endfunction

endpackage

// File: rtl/ctrlpid_mc_if.sv
// rtl/ctrlpid_mc_if.sv - per-channel operand fetch, output and status bundle of the multichannel PID
interface ctrlpid_mc_if #(
  parameter int aw = 2,
  parameter int ew = 24,
  parameter int ow = 12,
  parameter int cw = 6
);
  logic                 tick;
  logic [aw-1:0]        a;
  logic signed [ew-1:0] error;
  logic signed [cw-1:0] KP;
  logic signed [cw-1:0] KI;
  logic signed [cw-1:0] KD;
  logic [2:0]           mode;
  logic                 ch_en;
  logic signed [ow-1:0] m_k_out;
  logic [aw-1:0]        m_addr;
  logic                 m_valid;
  logic                 busy;
  logic                 overrun;

  modport master (
    output tick, error, KP, KI, KD, mode, ch_en,
    input  a, m_k_out, m_addr, m_valid, busy, overrun
  );

  modport slave (
    input  tick, error, KP, KI, KD, mode, ch_en,
    output a, m_k_out, m_addr, m_valid, busy, overrun
  );
endinterface

// File: rtl/ctrlpid_mc_shift.sv
// rtl/ctrlpid_mc_shift.sv - two-lane signed bidirectional arithmetic shifter sharing one signed amount
module ctrlpid_shift #(
  parameter int pw = 32,
  parameter int cw = 6
) (
  input  logic signed [pw-1:0] d0_i,
  input  logic signed [pw-1:0] d1_i,
  input  logic signed [cw-1:0] amt_i,
  output logic signed [pw-1:0] r0_o,
  output logic signed [pw-1:0] r1_o
);
  logic          left;
  logic [cw-1:0] mag;

  // Negating the most negative amount wraps to a value whose unsigned reading is its magnitude.
  always_comb begin
    left = ~amt_i[cw-1];
    mag  = left ? $unsigned(amt_i) : $unsigned(-amt_i);
  end

  function automatic logic signed [pw-1:0] sh(input logic signed [pw-1:0] d,
                                              input logic l, input logic [cw-1:0] m);
    if (int'(m) >= pw) return l ? '0 : {pw{d[pw-1]}};
    return l ? (d <<< m) : (d >>> m);
  endfunction

  always_comb begin
    r0_o = sh(d0_i, left, mag);
    r1_o = sh(d1_i, left, mag);
  end
endmodule

// File: rtl/ctrlpid_mc.sv
// rtl/ctrlpid_mc.sv - time-multiplexed N-channel shift-gain PID with sample tick, clamp and overrun flag
module ctrlpid_mc
  import ctrlpid_mc_pkg::*;
#(
  parameter int aw         = 2,
  parameter int ew         = 24,
  parameter int pw         = 32,
  parameter int ow         = 12,
  parameter int cw         = 6,
  parameter int precision  = 1,
  parameter int fp         = 9,
  parameter int antiwindup = antiwindup_default(precision, ow)
) (
  input logic clk_pid,
  input logic reset,
  ctrlpid_mc_if.slave bus
);
  localparam int an = 1 << aw;

  typedef logic signed [pw+1:0] acc_t;
  typedef logic signed [pw-1:0] word_t;
  typedef logic signed [cw-1:0] gain_t;

  localparam acc_t AW_POS = acc_t'(antiwindup);
  localparam acc_t AW_NEG = -AW_POS;

  state_e               state_q;
  logic [aw-1:0]        a_q;
  word_t                u_k_q [an];
  word_t                e0_q  [an];
  word_t                e1_q  [an];
  word_t                e2_q  [an];
  acc_t                 u_q;
  gain_t                kp_q, ki1_q, kd_q, kd1_q;
  logic [2:0]           mode_q;
  logic                 en_q;
  logic signed [ow-1:0] out_q;
  logic [aw-1:0]        maddr_q;
  logic                 mvalid_q, busy_q, overrun_q;

  gain_t sh_amt;
  word_t sh_d0, sh_d1, sh_r0, sh_r1;
  acc_t  term_d, sat_d;
  logic  term_en;

  function automatic acc_t ext(input word_t w);
    return {{2{w[pw-1]}}, w};
  endfunction

  ctrlpid_shift #(.pw(pw), .cw(cw)) u_shift (
    .d0_i  (sh_d0),
    .d1_i  (sh_d1),
    .amt_i (sh_amt),
    .r0_o  (sh_r0),
    .r1_o  (sh_r1)
  );

  always_comb begin
    sh_amt = kp_q;
    sh_d0  = e0_q[a_q];
    sh_d1  = e1_q[a_q];
    case (state_q)
      DTERM:  begin sh_amt = kd_q;  sh_d1 = e2_q[a_q]; end
      ITERM:  sh_amt = ki1_q;
      D2TERM: begin sh_amt = kd1_q; sh_d0 = e1_q[a_q]; end
      default: ;
    endcase
  end

  always_comb begin
    term_en = 1'b0;
    term_d  = u_q;
    case (state_q)
      PTERM:  begin term_en = en_q & mode_q[MODE_P]; term_d = u_q + ext(sh_r0) - ext(sh_r1); end
      DTERM:  begin term_en = en_q & mode_q[MODE_D]; term_d = u_q + ext(sh_r0) + ext(sh_r1); end
      ITERM:  begin term_en = en_q & mode_q[MODE_I]; term_d = u_q + ext(sh_r0) + ext(sh_r1); end
      D2TERM: begin term_en = en_q & mode_q[MODE_D]; term_d = u_q - ext(sh_r0); end
      default: ;
    endcase
    sat_d = (u_q > AW_POS) ? AW_POS : ((u_q < AW_NEG) ? AW_NEG : u_q);
  end

  always_ff @(posedge clk_pid or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      a_q       <= '0;
      u_q       <= '0;
      kp_q      <= '0;
      ki1_q     <= '0;
      kd_q      <= '0;
      kd1_q     <= '0;
      mode_q    <= '0;
      en_q      <= 1'b0;
      out_q     <= '0;
      maddr_q   <= '0;
      mvalid_q  <= 1'b0;
      busy_q    <= 1'b0;
      overrun_q <= 1'b0;
      for (int i = 0; i < an; i++) begin
        u_k_q[i] <= '0;
        e0_q[i]  <= '0;
        e1_q[i]  <= '0;
        e2_q[i]  <= '0;
      end
    end else begin
      mvalid_q <= 1'b0;
      if (bus.tick && state_q != IDLE) overrun_q <= 1'b1;
      case (state_q)
        IDLE: if (bus.tick) begin
          state_q <= LOAD;
          busy_q  <= 1'b1;
        end
        LOAD: begin
          kp_q   <= gain_t'(bus.KP + precision);
          ki1_q  <= gain_t'(bus.KI + precision - 1 - fp);
          kd_q   <= gain_t'(bus.KD + precision + fp);
          kd1_q  <= gain_t'(bus.KD + precision + fp + 1);
          mode_q <= bus.mode;
          en_q   <= bus.ch_en;
          if (bus.ch_en) begin
            e0_q[a_q] <= word_t'(bus.error);
            u_q       <= ext(u_k_q[a_q]);
          end else begin
            e0_q[a_q]  <= '0;
            e1_q[a_q]  <= '0;
            e2_q[a_q]  <= '0;
            u_k_q[a_q] <= '0;
            u_q        <= '0;
          end
          state_q <= PTERM;
        end
        PTERM:  begin if (term_en) u_q <= term_d; state_q <= DTERM;  end
        DTERM:  begin if (term_en) u_q <= term_d; state_q <= ITERM;  end
        ITERM:  begin if (term_en) u_q <= term_d; state_q <= D2TERM; end
        D2TERM: begin if (term_en) u_q <= term_d; state_q <= CLAMP;  end
        CLAMP: begin
          u_q        <= sat_d;
          u_k_q[a_q] <= word_t'(sat_d);
          state_q    <= OUT;
        end
        OUT: begin
          out_q    <= u_q[precision+ow-1:precision];
          maddr_q  <= a_q;
          mvalid_q <= 1'b1;
          state_q  <= SHIFT;
        end
        SHIFT: begin
          e2_q[a_q] <= e1_q[a_q];
          e1_q[a_q] <= e0_q[a_q];
          if (a_q == aw'(an - 1)) begin
            a_q     <= '0;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end else begin
            a_q     <= a_q + 1'b1;
            state_q <= LOAD;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.a       = a_q;
  assign bus.m_k_out = out_q;
  assign bus.m_addr  = maddr_q;
  assign bus.m_valid = mvalid_q;
  assign bus.busy    = busy_q;
  assign bus.overrun = overrun_q;
endmodule

// File: tb/tb_ctrlpid_mc.sv
// tb/tb_ctrlpid_mc.sv - bench for ctrlpid_mc against a per-channel arithmetic PID model
module tb_ctrlpid_mc;
  localparam int AW = 2, AN = 4, EW = 24, PW = 32, OW = 12, CW = 6, PREC = 1, FP = 9;
  localparam longint CLAMP_MAG = 4080;

  logic clk  = 1'b0;
  logic rst  = 1'b1;
  logic tick = 1'b0;
  int n_chk = 0, n_fail = 0, cyc = 0, last_valid_cyc = 0;

  logic signed [EW-1:0] err_a  [AN];
  logic signed [CW-1:0] kp_a   [AN];
  logic signed [CW-1:0] ki_a   [AN];
  logic signed [CW-1:0] kd_a   [AN];
  logic [2:0]           mode_a [AN];
  logic                 en_a   [AN];

  longint mu [AN], me0 [AN], me1 [AN], me2 [AN];
  int     last_out [AN];
  int     exp_addr_q [$];
  int     exp_out_q  [$];

  ctrlpid_mc_if #(.aw(AW), .ew(EW), .ow(OW), .cw(CW)) bus ();

  ctrlpid_mc #(.aw(AW), .ew(EW), .pw(PW), .ow(OW), .cw(CW), .precision(PREC), .fp(FP)) dut (
    .clk_pid (clk),
    .reset   (rst),
    .bus     (bus)
  );

  assign bus.tick  = tick;
  assign bus.error = err_a[bus.a];
  assign bus.KP    = kp_a[bus.a];
  assign bus.KI    = ki_a[bus.a];
  assign bus.KD    = kd_a[bus.a];
  assign bus.mode  = mode_a[bus.a];
  assign bus.ch_en = en_a[bus.a];

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string name, input longint act, input longint exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic longint sx(input longint x, input int n);
    return (x <<< (64 - n)) >>> (64 - n);
  endfunction

  function automatic longint shf(input longint v, input int s);
    if (s >= 0) return (s >= PW) ? 64'sd0 : sx(v << s, PW);
    if (-s >= PW) return (v < 0) ? -64'sd1 : 64'sd0;
    return v >>> (-s);
  endfunction

  function automatic void model_clear();
    for (int c = 0; c < AN; c++) begin
      mu[c] = 0; me0[c] = 0; me1[c] = 0; me2[c] = 0; last_out[c] = 0;
    end
    exp_addr_q.delete();
    exp_out_q.delete();
  endfunction

  // Velocity-form PID step for one channel, straight from the control law.
  function automatic void model_channel(input int c);
    longint u;
    int kp, ki1, kd, kd1;
    if (!en_a[c]) begin
      mu[c] = 0; me0[c] = 0; me1[c] = 0; me2[c] = 0;
      last_out[c] = 0;
    end else begin
      kp  = int'(sx(longint'(kp_a[c]) + PREC, CW));
      ki1 = int'(sx(longint'(ki_a[c]) + PREC - 1 - FP, CW));
      kd  = int'(sx(longint'(kd_a[c]) + PREC + FP, CW));
      kd1 = int'(sx(longint'(kd) + 1, CW));
      me0[c] = longint'(err_a[c]);
      u = mu[c];
      if (mode_a[c][0]) u = sx(u + shf(me0[c], kp) - shf(me1[c], kp), PW + 2);
      if (mode_a[c][2]) u = sx(u + shf(me0[c], kd) + shf(me2[c], kd), PW + 2);
      if (mode_a[c][1]) u = sx(u + shf(me0[c], ki1) + shf(me1[c], ki1), PW + 2);
      if (mode_a[c][2]) u = sx(u - shf(me1[c], kd1), PW + 2);
      if (u > CLAMP_MAG) u = CLAMP_MAG;
      else if (u < -CLAMP_MAG) u = -CLAMP_MAG;
      mu[c] = u;
      last_out[c] = int'(u >>> PREC);
      me2[c] = me1[c];
      me1[c] = me0[c];
    end
    exp_addr_q.push_back(c);
    exp_out_q.push_back(last_out[c]);
  endfunction

  always @(negedge clk) begin
    if (!rst && bus.m_valid) begin
      if (exp_out_q.size() == 0) begin
        check("unexpected m_valid", 1, 0);
      end else begin
        check("m_addr", longint'(bus.m_addr), longint'(exp_addr_q.pop_front()));
        check("m_k_out", longint'(bus.m_k_out), longint'(exp_out_q.pop_front()));
      end
      if (bus.m_addr != 0) check("m_valid spacing", cyc - last_valid_cyc, 8);
      last_valid_cyc = cyc;
    end
  end

  task automatic set_ch(input int c, input int e, input int kp, input int ki, input int kd,
                        input int m, input bit en);
    err_a[c] = EW'(e); kp_a[c] = CW'(kp); ki_a[c] = CW'(ki); kd_a[c] = CW'(kd);
    mode_a[c] = 3'(m); en_a[c] = en;
  endtask

  task automatic do_reset();
    rst = 1'b1; tick = 1'b0;
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    model_clear();
  endtask

  // Launches one sweep; extra_at > 0 raises a second tick during that busy cycle.
  task automatic sweep(input int extra_at);
    int bc = 0;
    for (int c = 0; c < AN; c++) model_channel(c);
    tick = 1'b1;
    @(negedge clk);
    tick = 1'b0;
    while (bus.busy && bc < 100) begin
      bc++;
      if (bc == extra_at) tick = 1'b1;
      @(negedge clk);
      tick = 1'b0;
    end
    check("busy cycles", bc, 8 * AN);
    @(negedge clk);
    check("busy after sweep", bus.busy, 0);
    check("pending outputs", exp_out_q.size(), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, n_chk %0d", n_chk);
    $fatal(1, "watchdog");
  end

  initial begin
    for (int c = 0; c < AN; c++) set_ch(c, 0, 0, 0, 0, 0, 1'b0);
    model_clear();
    @(negedge clk);
    check("reset m_k_out", longint'(bus.m_k_out), 0);
    check("reset m_addr", bus.m_addr, 0);
    check("reset m_valid", bus.m_valid, 0);
    check("reset busy", bus.busy, 0);
    check("reset overrun", bus.overrun, 0);
    check("reset a", bus.a, 0);
    do_reset();

    set_ch(0, 100, 0, 0, 0, 1, 1'b1);
    sweep(0);
    check("pin P sweep1", last_out[0], 100);
    sweep(0);
    check("pin P sweep2", last_out[0], 100);
    check("pin P u_k", mu[0], 200);

    do_reset();
    set_ch(0, 10, 0, 9, 0, 2, 1'b1);
    sweep(0); check("pin I sweep1", last_out[0], 5);
    sweep(0); check("pin I sweep2", last_out[0], 15);
    sweep(0); check("pin I sweep3", last_out[0], 25);

    do_reset();
    set_ch(0, 5000, 0, 0, 0, 1, 1'b1);
    sweep(0);
    check("pin clamp pos", last_out[0], 2040);
    check("pin clamp u_k", mu[0], CLAMP_MAG);
    en_a[0] = 1'b0;
    sweep(0);
    set_ch(0, -5000, 0, 0, 0, 1, 1'b1);
    sweep(0);
    check("pin clamp neg", last_out[0], -2040);
    check("pin clamp u_k neg", mu[0], -CLAMP_MAG);

    do_reset();
    set_ch(0, 10, 0, 0, 0, 1, 1'b1);
    set_ch(1, 20, 0, 0, 0, 1, 1'b1);
    set_ch(2, -30, 0, 0, 0, 1, 1'b1);
    set_ch(3, 0, 0, 0, 0, 1, 1'b1);
    sweep(0);
    check("pin multi ch1", last_out[1], 20);
    check("pin multi ch2", last_out[2], -30);

    check("overrun before", bus.overrun, 0);
    sweep(5);
    check("overrun after early tick", bus.overrun, 1);
    en_a[1] = 1'b0;
    sweep(0);
    check("pin disabled ch1", last_out[1], 0);
    sweep(32);
    check("no restart after final-shift tick", bus.busy, 0);
    set_ch(1, 10, 0, 9, 0, 2, 1'b1);
    sweep(0);
    check("pin ch1 history cleared", last_out[1], 5);

    do_reset();
    check("overrun cleared by reset", bus.overrun, 0);
    set_ch(0, 100, 0, 0, 0, 1, 1'b1);
    for (int c = 1; c < AN; c++) en_a[c] = 1'b0;
    for (int c = 0; c < AN; c++) model_channel(c);
    tick = 1'b1;
    @(negedge clk);
    tick = 1'b0;
    repeat (11) @(posedge clk);
    #2;
    check("m_k_out before mid reset", longint'(bus.m_k_out), 100);
    rst = 1'b1;
    #1;
    check("mid reset m_k_out", longint'(bus.m_k_out), 0);
    check("mid reset busy", bus.busy, 0);
    check("mid reset m_valid", bus.m_valid, 0);
    check("mid reset a", bus.a, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    model_clear();
    sweep(0);
    check("pin after mid reset", last_out[0], 100);

    do_reset();
    for (int s = 0; s < 40; s++) begin
      int extra;
      for (int c = 0; c < AN; c++) begin
        if ($urandom_range(0, 1) == 0) err_a[c] = EW'(int'($urandom_range(0, 400)) - 200);
        else err_a[c] = EW'($urandom);
        if ($urandom_range(0, 2) == 0) begin
          kp_a[c] = CW'($urandom); ki_a[c] = CW'($urandom); kd_a[c] = CW'($urandom);
        end else begin
          kp_a[c] = CW'(int'($urandom_range(0, 5)) - 3);
          ki_a[c] = CW'(int'($urandom_range(6, 11)));
          kd_a[c] = CW'(int'($urandom_range(0, 5)) - 13);
        end
        mode_a[c] = 3'($urandom_range(0, 7));
        en_a[c]   = ($urandom_range(0, 9) != 0);
      end
      extra = ($urandom_range(0, 9) == 0) ? int'($urandom_range(1, 32)) : 0;
      sweep(extra);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
